pipeline_hazard_ctrl: RTL

Central stall/flush controller for the five-stage pipeline. It watches the ID, ID/EX and EX/MEM register contents and the data-memory handshake, and drives per-stage enable, bubble and flush controls into the IF/ID, ID/EX, EX/MEM and MEM/WB buffers and the PC. It covers three hazard classes: load-use hazards, taken branches resolved in MEM, and multi-cycle data-memory waits. A wait-timeout watchdog flags memory accesses that never complete.

---
 rtl/pipeline_hazard_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline: load-use, taken-branch and data-memory wait hazards.
// Optional statistics counters are built when HAZARD_STATS_EN is defined.
module pipeline_hazard_ctrl #(
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned STAT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic              id_uses_rt,
    input  logic              ex_mem_read,
    input  logic [4:0]        ex_rt,
    input  logic              mem_branch,
    input  logic              mem_zf,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              pc_en,
    output logic              pc_src,
    output logic              ifid_en,
    output logic              ifid_flush,
    output logic              idex_en,
    output logic              idex_bubble,
    output logic              exmem_en,
    output logic              exmem_bubble,
    output logic              memwb_bubble,
`ifdef HAZARD_STATS_EN
    output logic [STAT_W-1:0] stall_cycles,
    output logic [STAT_W-1:0] flush_count,
`endif
    output logic              mem_timeout
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic             mem_timeout_nxt;

    logic memwait, taken, loaduse;

    // Hazard detection
    always_comb begin
        memwait = mem_req & ~mem_ready;
        taken   = mem_branch & mem_zf;
        loaduse = ex_mem_read & (ex_rt != 5'd0) &
                  ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
    end

    // Pipeline controls; memory wait freezes everything, then branch squash, then load-use stall
    always_comb begin
        pc_en        = 1'b1;
        pc_src       = 1'b0;
        ifid_en      = 1'b1;
        ifid_flush   = 1'b0;
        idex_en      = 1'b1;
        idex_bubble  = 1'b0;
        exmem_en     = 1'b1;
        exmem_bubble = 1'b0;
        memwb_bubble = 1'b0;
        if (!rst_n) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
        end else if (memwait) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_bubble = 1'b1;
        end else if (taken) begin
            pc_src       = 1'b1;
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            exmem_bubble = 1'b1;
        end else if (loaduse) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    // Wait-state tracking and watchdog
    always_comb begin
        state_nxt       = state;
        wait_cnt_nxt    = wait_cnt;
        mem_timeout_nxt = mem_timeout;
        case (state)
            RUN: begin
                if (memwait) begin
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = CNT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (memwait) begin
                    if (wait_cnt != CNT_MAX) begin
                        wait_cnt_nxt = wait_cnt + CNT_W'(1);
                    end
                end else begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt    = RUN;
                wait_cnt_nxt = '0;
            end
        endcase
        if ((state_nxt == MEM_WAIT) && (wait_cnt_nxt == WAIT_LIMIT)) begin
            mem_timeout_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_cnt_nxt;
            mem_timeout <= mem_timeout_nxt;
        end
    end

`ifdef HAZARD_STATS_EN
    // Saturating stall/flush statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!pc_en && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + STAT_W'(1);
            end
            if (pc_src && (flush_count != '1)) begin
                flush_count <= flush_count + STAT_W'(1);
            end
        end
    end
`endif

endmodule
